// File: rtl/tlb_refill_ctrl_pkg.sv
// Shared constants and types for the TLB refill walker.
// Page widths are derived from the page offset and the physical address size.
package tlb_refill_ctrl_pkg;

  localparam int OFFSET         = 12;
  localparam int PHYS_ADDR_SIZE = 20;
  localparam int VPN_W_DEF      = 32 - OFFSET;
  localparam int PPN_W_DEF      = PHYS_ADDR_SIZE - OFFSET;

  localparam int   PTE_VALID_BIT = 31;
  localparam logic TLB_SEL_I     = 1'b0;
  localparam logic TLB_SEL_D     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } walk_state_e;

endpackage

// File: rtl/tlb_refill_ctrl_rr_arb2.sv
// Two-way round-robin arbiter between ITLB and DTLB misses.
// On a tie the side not granted last wins; the last-grant bit updates on every grant.
module rr_arb2
  import tlb_refill_ctrl_pkg::*;
(
  input  logic clock,
  input  logic rst,
  input  logic en_i,
  input  logic req_i_i,
  input  logic req_d_i,
  output logic gnt_o,
  output logic sel_o
);

  logic last_q;

  always_comb begin
    gnt_o = en_i & (req_i_i | req_d_i);
    sel_o = (req_i_i & req_d_i) ? ~last_q : req_d_i;
  end

  // Reset to ITLB so that the first tie goes to the DTLB.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      last_q <= TLB_SEL_I;
    end else if (gnt_o) begin
      last_q <= sel_o;
    end
  end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// Single-level page-table walker refilling the ITLB/DTLB on a miss.
// Misses are sampled only in IDLE; a granted walk always completes even if its miss drops.
module tlb_refill_ctrl
  import tlb_refill_ctrl_pkg::*;
#(
  parameter logic [31:0] PT_BASE = 32'h0000_2000,
  parameter int          VPN_W   = VPN_W_DEF,
  parameter int          PPN_W   = PPN_W_DEF
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             itlb_miss,
  input  logic [VPN_W-1:0] itlb_vpage,
  input  logic             dtlb_miss,
  input  logic [VPN_W-1:0] dtlb_vpage,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             tlb_we,
  output logic             tlb_sel,
  output logic [VPN_W-1:0] tlb_vpage,
  output logic [PPN_W-1:0] tlb_ppage,
  output logic             itlb_ready,
  output logic             dtlb_ready,
  output logic             walk_fault,
  output logic [VPN_W-1:0] fault_vpage,
  output logic             busy
);

  walk_state_e      state_q, state_d;
  logic [VPN_W-1:0] vpage_q;
  logic             sel_q;
  logic [PPN_W-1:0] ppn_q;
  logic [VPN_W-1:0] fault_vpage_q;
  logic             gnt;
  logic             gnt_sel;
  logic [31:0]      pte_addr;
  logic             unused_rdata;

  assign unused_rdata = ^mem_rdata[PTE_VALID_BIT-1:PPN_W];

  rr_arb2 u_arb (
    .clock   (clock),
    .rst     (rst),
    .en_i    (state_q == ST_IDLE),
    .req_i_i (itlb_miss),
    .req_d_i (dtlb_miss),
    .gnt_o   (gnt),
    .sel_o   (gnt_sel)
  );

  assign pte_addr = PT_BASE + 32'({vpage_q, 2'b00});

  // Every output is decoded from registered state, so the async reset clears them at once.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_addr    = 32'h0;
    tlb_we      = 1'b0;
    tlb_sel     = 1'b0;
    tlb_vpage   = '0;
    tlb_ppage   = '0;
    itlb_ready  = 1'b0;
    dtlb_ready  = 1'b0;
    walk_fault  = 1'b0;
    busy        = (state_q != ST_IDLE);
    fault_vpage = fault_vpage_q;
    if (busy) tlb_sel = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt) state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_req  = 1'b1;
        mem_addr = pte_addr;
        if (mem_ack) state_d = mem_rdata[PTE_VALID_BIT] ? ST_WRITE : ST_FAULT;
      end
      ST_WRITE: begin
        tlb_we    = 1'b1;
        tlb_vpage = vpage_q;
        tlb_ppage = ppn_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        itlb_ready = (sel_q == TLB_SEL_I);
        dtlb_ready = (sel_q == TLB_SEL_D);
        state_d    = ST_IDLE;
      end
      ST_FAULT: begin
        walk_fault = 1'b1;
        itlb_ready = (sel_q == TLB_SEL_I);
        dtlb_ready = (sel_q == TLB_SEL_D);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      vpage_q       <= '0;
      sel_q         <= TLB_SEL_I;
      ppn_q         <= '0;
      fault_vpage_q <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        sel_q   <= gnt_sel;
        vpage_q <= gnt_sel ? dtlb_vpage : itlb_vpage;
      end
      if (state_q == ST_REQ && mem_ack) begin
        ppn_q <= mem_rdata[PPN_W-1:0];
        if (!mem_rdata[PTE_VALID_BIT]) fault_vpage_q <= vpage_q;
      end
    end
  end

endmodule
